iic_slave_regfile: RTL
======================

Name: iic_slave_regfile

Overview:
- I2C responder (target) with an embedded byte register file; it is the other end of the on-board I2C master.
- Gives an external I2C master (BMC/test host) access to CPLD registers, and serves as the loopback target for the I2C master in board self-test.
- The local-bus side reads and writes the same register file through a simple host port.

Parameters:
- DEV_ID, 7'h50, 7-bit I2C address this target answers to.
- MEM_AW, 4, register-file address width (2**MEM_AW bytes).
- FILT_LEN, 3, consecutive equal synchronized samples needed to accept a new SCL/SDA level.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (open drain, external pull-up).
- wp  in  1  write protect for I2C writes (host port unaffected).
- host_addr  in  MEM_AW  host register address.
- host_we  in  1  host write strobe, one clk.
- host_wdata  in  8  host write data.
- host_rdata  out  8  registered read data for host_addr, 1 clk latency.
- busy  out  1  target addressed; transaction in progress.
- wr_done  out  1  one-clk pulse on STOP ending a write that stored at least one data byte.

Behaviour:
- Reset:
  - sda_oe=0, busy=0, wr_done=0, host_rdata=0.
  - All register bytes=0x00, pointer=0, FSM=IDLE.
  - Reset mid-transfer releases SDA on the next clk.
- Input conditioning:
  - 2-FF synchronizer per line, then FILT_LEN-deep filter producing scl_f/sda_f.
  - Pin-to-filtered latency is 2+FILT_LEN clk.
- Bus events:
  - START: sda_f falls while scl_f=1. Accepted in any state, including repeated START. Goes to DEVADDR, clears bit counter, keeps pointer.
  - STOP: sda_f rises while scl_f=1. Goes to IDLE from any state, releases SDA, clears busy.
- Bit timing:
  - Shift in on scl_f rise; MSB first.
  - Change sda_oe only on the clk after scl_f fall, so SDA is stable for the whole SCL high phase.
- FSM states: IDLE, DEVADDR, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
  - DEVADDR: after 8 bits, if addr[7:1]==DEV_ID then ACK (sda_oe=1 for the 9th SCL) and set busy. R/W=0 goes to WADDR; R/W=1 goes to RDATA with the byte at pointer loaded into the shifter. Otherwise NACK and go to WAIT_STOP.
  - WADDR: 8 bits, always ACK. pointer = byte[MEM_AW-1:0]; upper bits ignored. Next state WDATA.
  - WDATA: 8 bits, always ACK.
    - wp=0: store at pointer.
    - wp=1: discard.
    - Pointer increments in both cases.
  - RDATA: drive bits MSB first; sda_oe = ~bit.
  - RACK: release SDA and sample the master bit on the 9th SCL.
    - ACK (0): pointer+1, load the next byte, back to RDATA.
    - NACK (1): pointer+1, go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for START or STOP.
- Pointer wraps 2**MEM_AW-1 to 0 on both read and write.
- Random read = write of the word address, repeated START, then read.
- Collision: I2C store and host_we on the same clk to the same address, I2C data wins. Different addresses both complete.
- host_rdata reflects any write committed in the previous clk.
- wr_done pulses on STOP only if at least one byte was stored (wp=0) since the matching START.
- STOP or START mid-byte aborts the byte; partial bits are discarded and nothing is stored.
- SCL held low indefinitely: FSM holds state and sda_oe. No clock stretching; sda_oe never drives SCL.

Test Plan:
- Write then random read:
  - Stimulus: START, 0xA0, 0x05, 0x11, 0x22, STOP.
  - Response: four ACKs, wr_done pulse; host read of 0x05/0x06 returns 0x11/0x22.
  - Then START, 0xA0, 0x05, rSTART, 0xA1, read 2 bytes (ACK, NACK), STOP returns 0x11, 0x22; sda_oe stays 0 after NACK.
- Address mismatch:
  - Stimulus: START, 0xA2, ...
  - Response: 9th bit NACK (sda_oe=0 throughout), busy=0, memory unchanged.
- Wrap-around:
  - Stimulus: write at 0x0F of 0xAA, 0xBB.
  - Response: regs[0x0F]=0xAA, regs[0x00]=0xBB.
  - A sequential read from 0x0F returns 0xAA, 0xBB.
- Write protect:
  - Stimulus: wp=1, write 0x33 at 0x02.
  - Response: ACKed, regs[0x02] unchanged, no wr_done.
- Collision:
  - Stimulus: host_we to 0x03 with 0x55 on the same clk as the I2C store of 0x66 to 0x03.
  - Response: host_rdata for 0x03 returns 0x66.
- Abort:
  - STOP after 4 data bits: nothing stored, FSM=IDLE.
  - rst asserted while driving a 0 read bit: sda_oe=0 next clk, registers cleared.

Source files
------------

// File: rtl/iic_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module  : iic_slave_regfile
// Brief   : I2C target with embedded byte register file and local host port
// Rev     : 1.0  initial release
// ============================================================================
module iic_slave_regfile #(
  parameter logic [6:0] DEV_ID   = 7'h50,
  parameter int         MEM_AW   = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              wp,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              wr_done
);

  localparam int c_depth = 2 ** MEM_AW;
  localparam int c_cw    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEV_ACK, WADDR, WADDR_ACK,
    WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA through the conditioning chain.
  logic [1:0] pin_s1_q, pin_s2_q, filt_q, filt_d, filt_p_q;

  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            w_flip;

    assign w_flip    = (pin_s2_q[i] != filt_q[i]) && (cnt_q == c_cw'(FILT_LEN - 1));
    assign cnt_d     = ((pin_s2_q[i] == filt_q[i]) || w_flip) ? '0 : cnt_q + 1'b1;
    assign filt_d[i] = w_flip ? pin_s2_q[i] : filt_q[i];

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pin_s1_q <= 2'b11;
      pin_s2_q <= 2'b11;
      filt_q   <= 2'b11;
      filt_p_q <= 2'b11;
    end else begin
      pin_s1_q <= {sda_in, scl_in};
      pin_s2_q <= pin_s1_q;
      filt_q   <= filt_d;
      filt_p_q <= filt_q;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_f;
  assign w_sda_f    = filt_q[1];
  assign w_scl_rise =  filt_q[0] & ~filt_p_q[0];
  assign w_scl_fall = ~filt_q[0] &  filt_p_q[0];
  assign w_start    =  filt_q[0] &  filt_p_q[0] &  filt_p_q[1] & ~filt_q[1];
  assign w_stop     =  filt_q[0] &  filt_p_q[0] & ~filt_p_q[1] &  filt_q[1];

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              stored_q, stored_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_done_q, wr_done_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic [7:0]        mem_q [c_depth];
  logic [7:0]        mem_d [c_depth];

  logic [7:0]        w_byte;
  logic              w_last_bit;
  logic [MEM_AW-1:0] w_ptr_inc;
  logic              w_store;

  assign w_byte     = {shift_q[6:0], w_sda_f};
  assign w_last_bit = (bit_cnt_q == 3'd7);
  assign w_ptr_inc  = ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    stored_d  = stored_q;
    sda_oe_d  = sda_oe_q;
    wr_done_d = 1'b0;
    w_store   = 1'b0;

    if (w_stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      wr_done_d = stored_q;
      stored_d  = 1'b0;
    end else if (w_start) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (w_scl_rise) begin
      case (state_q)
        DEVADDR, WADDR, WDATA: begin
          // The 3-bit counter wraps to 0 on the 8th bit, ready for the next byte.
          shift_d   = w_byte;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (w_last_bit) begin
            case (state_q)
              DEVADDR: begin
                if (w_byte[7:1] == DEV_ID) begin
                  state_d = DEV_ACK;
                  busy_d  = 1'b1;
                  rw_d    = w_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                end
              end
              WADDR: begin
                ptr_d   = w_byte[MEM_AW-1:0];
                state_d = WADDR_ACK;
              end
              default: begin
                w_store  = ~wp;
                stored_d = stored_q | ~wp;
                ptr_d    = w_ptr_inc;
                state_d  = WDATA_ACK;
              end
            endcase
          end
        end
        DEV_ACK: begin
          if (rw_q) begin
            state_d = RDATA;
            shift_d = mem_q[ptr_q];
          end else begin
            state_d = WADDR;
          end
        end
        WADDR_ACK, WDATA_ACK: state_d = WDATA;
        RDATA: begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (w_last_bit) state_d = RACK;
        end
        RACK: begin
          ptr_d = w_ptr_inc;
          if (!w_sda_f) begin
            state_d = RDATA;
            shift_d = mem_q[w_ptr_inc];
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end else if (w_scl_fall) begin
      // SDA only moves while SCL is low, so it is stable across the high phase.
      case (state_q)
        DEV_ACK, WADDR_ACK, WDATA_ACK: sda_oe_d = 1'b1;
        RDATA:                         sda_oe_d = ~shift_q[7];
        default:                       sda_oe_d = 1'b0;
      endcase
    end
  end

  // Host write applied first so a same-address I2C store overrides it.
  always_comb begin
    mem_d = mem_q;
    if (host_we) mem_d[host_addr] = host_wdata;
    if (w_store) mem_d[ptr_q] = w_byte;
    host_rdata_d = mem_q[host_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      stored_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      wr_done_q    <= 1'b0;
      host_rdata_q <= '0;
      for (int i = 0; i < c_depth; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      stored_q     <= stored_d;
      sda_oe_q     <= sda_oe_d;
      wr_done_q    <= wr_done_d;
      host_rdata_q <= host_rdata_d;
      mem_q        <= mem_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_done    = wr_done_q;
  assign host_rdata = host_rdata_q;

endmodule
`default_nettype wire
